// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  // Default PC step for one sequential fetch (one 32-bit word).
  localparam int unsigned INC_DEFAULT = 4;

endpackage

// File: rtl/fetch_controller_instr_latch.sv
// Capture register for the fetched word handed to decode.
// A load has priority over a drop so a word captured in the same cycle
// the previous one is consumed is never lost.
module instr_latch #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         drop,
  input  logic [N-1:0] data_in,
  input  logic [N-1:0] pc_in,
  output logic         valid,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc
);

  // Hold the word and its PC; valid tracks whether decode still owns it.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      valid    <= 1'b0;
      instr    <= '0;
      instr_pc <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= data_in;
      instr_pc <= pc_in;
    end else if (drop) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: steers the external PC register, issues one
// outstanding instruction-memory request at a time and presents the
// returned word to decode. Redirect beats halt beats normal flow.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int N   = 32,
  parameter int INC = INC_DEFAULT
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [N-1:0] pc_cur,
  output logic         pc_load,
  output logic [N-1:0] pc_next,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic         instr_valid,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc,
  input  logic         instr_ready,
  input  logic         stall,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  input  logic         halt,
  output logic         busy
);

  localparam logic [N-1:0] STEP = N'(INC);

  fetch_state_t state, next_state;
  logic         load_raw;
  logic         latch_load;
  logic         latch_drop;
  logic [N-1:0] pc_plus;

  // Sequential successor; the adder width makes the wrap at 2^N implicit.
  assign pc_plus = pc_cur + STEP;

  // State register; async clear forces IDLE so the request drops at once.
  always_ff @(posedge clk or negedge clr) begin
    // NOTE: state elements use non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!clr) state <= IDLE;
    else      state <= next_state;
  end

  // Next state, PC steering, memory request and capture control.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can
    // leave a signal unassigned and infer a latch.
    next_state = state;
    load_raw   = 1'b0;
    pc_next    = pc_plus;
    imem_req   = 1'b0;
    imem_addr  = pc_cur;
    latch_load = 1'b0;
    latch_drop = 1'b0;

    unique case (state)
      IDLE: begin
        if (redirect) begin
          // Sets the start address without leaving IDLE.
          load_raw = 1'b1;
          pc_next  = redirect_pc;
        end else if (start) begin
          next_state = REQ;
        end
      end

      REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          // Any ack in this cycle belongs to the stale path and is ignored.
          load_raw = 1'b1;
          pc_next  = redirect_pc;
        end else if (imem_ack) begin
          load_raw = 1'b1;
          if (halt) begin
            next_state = HALTED;
          end else begin
            latch_load = 1'b1;
            next_state = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          load_raw   = 1'b1;
          pc_next    = redirect_pc;
          latch_drop = 1'b1;
          next_state = REQ;
        end else if (halt) begin
          latch_drop = 1'b1;
          next_state = HALTED;
        end else if (instr_ready && !stall) begin
          latch_drop = 1'b1;
          next_state = REQ;
        end
      end

      HALTED: begin
        // Terminal until clr; inputs are ignored.
      end

      default: next_state = IDLE;
    endcase
  end

  // Never disturb the PC register while it is being cleared.
  assign pc_load = load_raw & clr;
  assign busy    = (state == REQ) || (state == HOLD);

  instr_latch #(.N(N)) u_instr_latch (
    .clk     (clk),
    .clr     (clr),
    .load    (latch_load),
    .drop    (latch_drop),
    .data_in (imem_rdata),
    .pc_in   (pc_cur),
    .valid   (instr_valid),
    .instr   (instr),
    .instr_pc(instr_pc)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus randomized traffic,
// all checked against a transaction-level model of the fetch stage.
module tb_fetch_controller;

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] pc_cur;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Model: what the fetch stage is doing, the PC it holds and the word
  // decode currently sees.
  localparam int M_IDLE = 0, M_FETCH = 1, M_OFFER = 2, M_STOP = 3;
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;

  logic [31:0] addr_log[$];
  int          load_count;

  fetch_controller #(.N(32), .INC(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .pc_cur     (pc_cur),
    .pc_load    (pc_load),
    .pc_next    (pc_next),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .busy       (busy)
  );

  // PC register living beside the controller at the fetch-stage top.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)         pc_cur <= '0;
    else if (pc_load) pc_cur <= pc_next;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_pc    = '0;
    m_valid = 1'b0;
    m_instr = '0;
    m_ipc   = '0;
  endtask

  task automatic idle_inputs();
    start       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    clr = 1'b1;
    model_reset();
  endtask

  // One cycle: inputs are already driven; check outputs mid-cycle, then
  // advance the model across the edge.
  task automatic step();
    logic        exp_load;
    logic [31:0] exp_next;
    #4;
    if (redirect) exp_load = (m_mode != M_STOP);
    else          exp_load = (m_mode == M_FETCH) && imem_ack;
    exp_next = redirect ? redirect_pc : m_pc + 32'd4;
    check("pc_reg", pc_cur, m_pc);
    check("pc_load", {31'd0, pc_load}, {31'd0, exp_load});
    if (exp_load) check("pc_next", pc_next, exp_next);
    check("imem_req", {31'd0, imem_req}, {31'd0, m_mode == M_FETCH});
    if (m_mode == M_FETCH) check("imem_addr", imem_addr, m_pc);
    check("busy", {31'd0, busy}, {31'd0, (m_mode == M_FETCH) || (m_mode == M_OFFER)});
    check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("instr", instr, m_instr);
      check("instr_pc", instr_pc, m_ipc);
    end
    if (imem_req) addr_log.push_back(imem_addr);
    if (pc_load) load_count++;
    @(posedge clk);
    case (m_mode)
      M_IDLE: begin
        if (redirect)   m_pc = redirect_pc;
        else if (start) m_mode = M_FETCH;
      end
      M_FETCH: begin
        if (redirect) begin
          m_pc = redirect_pc;
        end else if (imem_ack) begin
          if (halt) begin
            m_mode = M_STOP;
          end else begin
            m_instr = imem_rdata;
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_mode  = M_OFFER;
          end
          m_pc = m_pc + 32'd4;
        end
      end
      M_OFFER: begin
        if (redirect) begin
          m_valid = 1'b0;
          m_pc    = redirect_pc;
          m_mode  = M_FETCH;
        end else if (halt) begin
          m_valid = 1'b0;
          m_mode  = M_STOP;
        end else if (instr_ready && !stall) begin
          m_valid = 1'b0;
          m_mode  = M_FETCH;
        end
      end
      default: ;
    endcase
    #1;
  endtask

  initial begin
    int halted_cycles;
    clr = 1'b1;
    idle_inputs();
    #1;
    do_reset();

    // Reset state.
    #3;
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pc_load", {31'd0, pc_load}, 32'd0);
    @(posedge clk);
    #1;

    // Zero-wait streaming: addresses 0,4,8,12 on alternate cycles.
    addr_log.delete();
    load_count = 0;
    start = 1'b1;
    step();
    start       = 1'b0;
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      imem_rdata = 32'hA000_0000 + i;
      step();
    end
    check("seq_req_count", addr_log.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < addr_log.size()) check("seq_addr", addr_log[i], 32'(4 * i));
    check("seq_loads", load_count, 32'd4);

    // Redirect coinciding with ack: data discarded, fetch moves to 0x100.
    imem_ack    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    redirect = 1'b0;
    imem_ack = 1'b0;
    #4;
    check("redir_valid", {31'd0, instr_valid}, 32'd0);
    check("redir_addr", imem_addr, 32'h100);
    @(posedge clk);
    #1;

    // Stall in HOLD for 3 cycles, then release.
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack    = 1'b0;
    stall       = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("stall_instr", instr, 32'h1234_5678);
    stall = 1'b0;
    step();
    step();

    // Wrap-around of the sequential PC.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect   = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0BAD_F00D;
    step();
    imem_ack = 1'b0;
    check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    step();
    #4;
    check("wrap_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;

    // Halt while offering a word: everything freezes until clr.
    do_reset();
    start = 1'b1;
    step();
    start      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    step();
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    halt        = 1'b1;
    step();
    halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start       = 1'b1;
      redirect    = i[0];
      redirect_pc = 32'h400;
      imem_ack    = 1'b1;
      instr_ready = 1'b1;
      step();
    end
    check("halt_busy", {31'd0, busy}, 32'd0);
    idle_inputs();

    // clr mid-REQ with ack pending.
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    #4;
    check("clr_pre_req", {31'd0, imem_req}, 32'd1);
    clr = 1'b0;
    #1;
    check("clr_req", {31'd0, imem_req}, 32'd0);
    check("clr_valid", {31'd0, instr_valid}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    #1;
    check("clr_no_load", {31'd0, pc_load}, 32'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    clr      = 1'b1;
    model_reset();
    #1;
    check("clr_pc_zero", pc_cur, 32'd0);
    check("clr_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    // clr while a word is offered: valid drops immediately.
    start = 1'b1;
    step();
    start    = 1'b0;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    #4;
    check("clr_hold_pre", {31'd0, instr_valid}, 32'd1);
    clr = 1'b0;
    #1;
    check("clr_hold_valid", {31'd0, instr_valid}, 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    model_reset();

    // Randomized traffic.
    halted_cycles = 0;
    for (int i = 0; i < 600; i++) begin
      start       = ($urandom % 4) == 0;
      imem_ack    = ($urandom % 2) == 0;
      imem_rdata  = $urandom;
      instr_ready = ($urandom % 4) != 0;
      stall       = ($urandom % 4) == 0;
      redirect    = ($urandom % 12) == 0;
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      halt        = ($urandom % 30) == 0;
      step();
      if (m_mode == M_STOP) halted_cycles++;
      if (halted_cycles > 4) begin
        halted_cycles = 0;
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for the program counter register: decides every cycle whether the PC loads, and with what value. It drives a single-outstanding instruction-memory request at the current PC and holds the returned word for decode. It also applies branch redirects, decode back-pressure (stall) and halt. It sits between the PC register, instruction memory and the decode stage, and drives the PC register's `load`/`pc_in` directly.

## Interface
- `N`, 32, address/instruction width
- `INC`, 4, PC step per sequential fetch
- `clk` in 1: single clock, rising edge
- `clr` in 1: asynchronous, active-low reset
- `start` in 1: leave IDLE and begin fetching
- `pc_cur` in N: current PC (PC register output)
- `pc_load` out 1: load strobe to PC register
- `pc_next` out N: value loaded when `pc_load`=1
- `imem_req` out 1 / `imem_addr` out N: memory request and address
- `imem_ack` in 1 / `imem_rdata` in N: memory completion and read data
- `instr_valid` out 1 / `instr` out N / `instr_pc` out N: fetched word to decode
- `instr_ready` in 1: decode accepts word
- `stall` in 1: decode back-pressure, overrides `instr_ready`
- `redirect` in 1 / `redirect_pc` in N: branch/jump target
- `halt` in 1: stop fetching after the current transaction
- `busy` out 1: state is REQ or HOLD

## Operation
- States: IDLE, REQ, HOLD, HALTED.
- Priority each cycle: redirect > halt > normal.
- IDLE
  - `imem_req`=0.
  - `redirect` → `pc_load`=1, `pc_next`=`redirect_pc`, stay IDLE. This sets the start address.
  - Else `start` → REQ.
- REQ
  - `imem_req`=1, `imem_addr`=`pc_cur`. Both held stable until `imem_ack`.
  - `redirect` without ack → load `redirect_pc`. The address follows the new PC next cycle; the request stays asserted.
  - `imem_ack` without redirect → capture `imem_rdata` into `instr` and `pc_cur` into `instr_pc`, then load `pc_cur+INC`.
    - `halt`=1 → HALTED (captured word discarded).
    - Else → HOLD.
  - `imem_ack` with `redirect` → discard data, load `redirect_pc`, stay REQ.
- HOLD
  - `instr_valid`=1, `imem_req`=0.
  - Handshake = `instr_ready` & !`stall`; on handshake → REQ.
  - `redirect` → drop the word (`instr_valid`=0 next cycle), load `redirect_pc`, → REQ.
  - `halt` (no redirect) → HALTED, word dropped.
- HALTED
  - All requests off, all inputs ignored.
  - Exit only via `clr`.
- Arithmetic: `pc_cur+INC` is modulo 2^N; 0xFFFFFFFC+4 wraps to 0.

## Timing
- Reset values:
  - State IDLE.
  - `instr_valid`=0, `instr`=0, `instr_pc`=0.
  - `imem_req`=0, `pc_load`=0, `busy`=0.
- `pc_load`/`pc_next` are combinational from state and inputs, so the PC register updates on the same edge that ends the cycle.
- `imem_req`/`imem_addr` are combinational from state and `pc_cur`.
- `instr`, `instr_pc`, `instr_valid` are registered.
- Ack in cycle t → `instr_valid` and new `pc_cur` in cycle t+1.
- Best-case throughput, zero-wait memory and ready decode: one instruction per 2 cycles.
- `clr` asserted mid-transaction:
  - State goes to IDLE asynchronously.
  - `imem_req` and `instr_valid` drop immediately.
  - Instruction memory tolerates an abandoned request.
- `pc_load` is never asserted while `clr`=0.

## Structure
- Shared package `fetch_pkg` holds:
  - `fetch_state_t` enum (IDLE, REQ, HOLD, HALTED);
  - default `INC` constant.
- One natural sub-module, `instr_latch`: the `instr`/`instr_pc`/`instr_valid` capture register with load, clear and async `clr`.
- The PC register is instantiated beside this block at the fetch-stage top, not inside it.

## Test plan
- Reset then `start`, memory acks every REQ cycle, `instr_ready`=1 → `imem_addr` 0,4,8,12 on alternating cycles; `instr_pc` matches; `pc_load` pulses once per fetch.
- `redirect`=1 with `redirect_pc`=0x100 in the same cycle as `imem_ack` → word discarded, `instr_valid` stays 0, next `imem_addr`=0x100.
- HOLD with `stall`=1 for 3 cycles and `instr_ready`=1 → `instr` stable, no `pc_load`, no request; REQ resumes the cycle after `stall` drops.
- `pc_cur`=0xFFFFFFFC, ack → `pc_next`=0, next `imem_addr`=0.
- `halt` in HOLD → HALTED, `busy`=0; a later `start`/`redirect` has no effect until `clr`.
- `clr` pulsed low while in REQ with ack pending → `imem_req`=0 and `instr_valid`=0 immediately; IDLE after release; PC register reads 0.
